// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID check master.
package sysid_check_pkg;

  localparam int unsigned TMR_W  = 16;
  localparam int unsigned DATA_W = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ID_REQ,
    ID_WAIT,
    TS_REQ,
    TS_WAIT,
    FIN
  } state_e;

  // Word address presented on the bus while in a given state.
  function automatic logic word_addr(input state_e s);
    return (s == TS_REQ || s == TS_WAIT) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  endfunction

endpackage

// File: rtl/avm_rd_timer.sv
// Per-transaction cycle counter; expired_c flags the last allowed cycle.
module avm_rd_timer
  import sysid_check_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMR_W-1:0] limit,
  output logic             expired_c
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // The count including the current cycle is cnt_q+1; expiry when it equals limit-1.
  always_comb begin
    cnt_d     = cnt_q;
    expired_c = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d     = cnt_q + TMR_W'(1);
      expired_c = (cnt_q == limit - TMR_W'(2));
    end
  end

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM read master checking the system-ID slave against build-time values.
// Define SYSID_TS_CHECK_EN to also read and compare the build timestamp (word 1).
module sysid_check_master
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
`ifdef SYSID_TS_CHECK_EN
  parameter logic [31:0] EXPECTED_TS    = 32'd1521151335,
`endif
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              id_ok_q, id_ok_d;
  logic              timeout_err_q, timeout_err_d;
  logic [DATA_W-1:0] id_value_q, id_value_d;
  logic              avm_read_q, avm_read_d;
  logic              tmr_clear, tmr_enable, tmr_expired_c;

  avm_rd_timer u_timer (
    .clock     (clock),
    .reset     (reset),
    .clear     (tmr_clear),
    .enable    (tmr_enable),
    .limit     (TMR_W'(TIMEOUT_CYCLES)),
    .expired_c (tmr_expired_c)
  );

`ifdef SYSID_TS_CHECK_EN
  logic ts_ok_q, ts_ok_d;
  logic avm_address_q, avm_address_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_ok_q       <= 1'b0;
      avm_address_q <= 1'b0;
    end else begin
      ts_ok_q       <= ts_ok_d;
      avm_address_q <= avm_address_d;
    end
  end

  assign ts_ok       = ts_ok_q;
  assign avm_address = avm_address_q;
`else
  assign ts_ok       = 1'b0;
  assign avm_address = SYSID_ADDR_ID;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      id_value_q    <= '0;
      avm_read_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      id_ok_q       <= id_ok_d;
      timeout_err_q <= timeout_err_d;
      id_value_q    <= id_value_d;
      avm_read_q    <= avm_read_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    id_ok_d       = id_ok_q;
    timeout_err_d = timeout_err_q;
    id_value_d    = id_value_q;
    tmr_clear     = 1'b0;
    tmr_enable    = (state_q == ID_REQ) || (state_q == ID_WAIT) ||
                    (state_q == TS_REQ) || (state_q == TS_WAIT);
`ifdef SYSID_TS_CHECK_EN
    ts_ok_d       = ts_ok_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          id_ok_d       = 1'b0;
          timeout_err_d = 1'b0;
`ifdef SYSID_TS_CHECK_EN
          ts_ok_d       = 1'b0;
`endif
          tmr_clear     = 1'b1;
          state_d       = ID_REQ;
        end
      end
      // Request phase: the timeout wins over a late acceptance.
      ID_REQ: begin
        if (tmr_expired_c) begin
          timeout_err_d = 1'b1;
          state_d       = FIN;
        end else if (!avm_waitrequest) begin
          state_d = ID_WAIT;
        end
      end
      // Data phase: data on the timeout cycle is still taken.
      ID_WAIT: begin
        if (avm_readdatavalid) begin
          id_value_d = avm_readdata;
          id_ok_d    = (avm_readdata == EXPECTED_ID);
`ifdef SYSID_TS_CHECK_EN
          tmr_clear  = 1'b1;
          state_d    = TS_REQ;
`else
          state_d    = FIN;
`endif
        end else if (tmr_expired_c) begin
          timeout_err_d = 1'b1;
          state_d       = FIN;
        end
      end
`ifdef SYSID_TS_CHECK_EN
      TS_REQ: begin
        if (tmr_expired_c) begin
          timeout_err_d = 1'b1;
          state_d       = FIN;
        end else if (!avm_waitrequest) begin
          state_d = TS_WAIT;
        end
      end
      TS_WAIT: begin
        if (avm_readdatavalid) begin
          ts_ok_d = (avm_readdata == EXPECTED_TS);
          state_d = FIN;
        end else if (tmr_expired_c) begin
          timeout_err_d = 1'b1;
          state_d       = FIN;
        end
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    done_d     = (state_q == FIN);
    avm_read_d = (state_d == ID_REQ) || (state_d == TS_REQ);
`ifdef SYSID_TS_CHECK_EN
    avm_address_d = word_addr(state_d);
`endif
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign timeout_err = timeout_err_q;
  assign id_value    = id_value_q;
  assign avm_read    = avm_read_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench for sysid_check_master with a small Avalon slave model.
module tb_sysid_check_master;

  localparam int unsigned TMO = 8;
`ifdef SYSID_TS_CHECK_EN
  localparam int LAT_PASS = 6;
  localparam logic TS_EXP = 1'b1;
`else
  localparam int LAT_PASS = 4;
  localparam logic TS_EXP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout_err;
  logic [31:0] id_value;
  logic        avm_address, avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  // Slave configuration, written only by the main sequence while idle.
  logic [31:0] mem0 = 32'd0;
  logic [31:0] mem1 = 32'd1521151335;
  int          stall_cfg = 0;
  logic        drop_rdv = 1'b0;
  logic        stray_tgl = 1'b0;
  logic        addr_one_seen;

  int total  = 0;
  int passed = 0;
  int lat;
  int done_pulses;

  sysid_check_master #(
    .EXPECTED_ID    (32'd0),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .id_ok             (id_ok),
    .ts_ok             (ts_ok),
    .timeout_err       (timeout_err),
    .id_value          (id_value),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clock = ~clock;

  // Slave model: drives its outputs on the falling edge.
  initial begin
    logic        pending;
    logic [31:0] pend_data;
    logic        stray_last;
    int          req_cycles;
    pending = 1'b0; pend_data = '0; stray_last = 1'b0; req_cycles = 0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
    addr_one_seen = 1'b0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = pending;
      avm_readdata      = pending ? pend_data : 32'h0;
      pending           = 1'b0;
      if (stray_tgl != stray_last) begin
        stray_last        = stray_tgl;
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h0;
      end
      if (avm_address) addr_one_seen = 1'b1;
      if (avm_read && !reset) begin
        if (avm_address == 1'b0 && req_cycles < stall_cfg) begin
          avm_waitrequest = 1'b1;
        end else begin
          avm_waitrequest = 1'b0;
          if (!drop_rdv) begin
            pending   = 1'b1;
            pend_data = avm_address ? mem1 : mem0;
          end
        end
        req_cycles++;
      end else begin
        avm_waitrequest = 1'b0;
        req_cycles      = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  // Waits (bounded) for done; lat counts cycles from start acceptance.
  task automatic wait_done(input string tag, input int lat0, output int lat_o);
    lat_o = lat0;
    while (done !== 1'b1 && lat_o < 40) begin
      @(negedge clock);
      lat_o++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  initial begin
    // Reset state.
    #1 reset = 1'b1;
    #2;
    chk("rst_outs", 32'({busy, done, id_ok, ts_ok, timeout_err, avm_read, avm_address}), 32'd0);
    chk("rst_id_value", id_value, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // 1: zero-wait pass.
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1", 1, lat);
    chk("t1_lat", 32'(lat), 32'(LAT_PASS));
    chk("t1_busy_at_done", 32'(busy), 32'd0);
    chk("t1_id_ok", 32'(id_ok), 32'd1);
    chk("t1_ts_ok", 32'(ts_ok), 32'(TS_EXP));
    chk("t1_timeout", 32'(timeout_err), 32'd0);
    chk("t1_id_value", id_value, 32'd0);
    @(negedge clock);
    chk("t1_done_one_cycle", 32'(done), 32'd0);

    // 3: five stall cycles; data lands on the last allowed cycle.
    stall_cfg = 5;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clock);
      chk($sformatf("t3_read_%0d", i), 32'(avm_read), 32'd1);
      chk($sformatf("t3_addr_%0d", i), 32'(avm_address), 32'd0);
    end
    wait_done("t3", 6, lat);
    chk("t3_lat", 32'(lat), 32'(LAT_PASS + 5));
    chk("t3_id_ok", 32'(id_ok), 32'd1);
    chk("t3_timeout", 32'(timeout_err), 32'd0);
    @(negedge clock);
    stall_cfg = 0;

    // 2: wrong ID, with a second start while busy.
    mem0 = 32'hDEADBEEF;
    done_pulses = 0;
    pulse_start();
    start = 1'b1;
    @(negedge clock) start = 1'b0;
    wait_done("t2", 2, lat);
    chk("t2_lat", 32'(lat), 32'(LAT_PASS));
    chk("t2_id_value", id_value, 32'hDEADBEEF);
    chk("t2_id_ok", 32'(id_ok), 32'd0);
    chk("t2_ts_ok", 32'(ts_ok), 32'(TS_EXP));
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      done_pulses += int'(done);
      chk($sformatf("t2_idle_busy_%0d", i), 32'(busy), 32'd0);
    end
    chk("t2_done_pulses", 32'(done_pulses), 32'd0);

    // Stray readdatavalid while idle must not disturb results.
    stray_tgl = ~stray_tgl;
    repeat (3) @(negedge clock);
    chk("stray_id_value", id_value, 32'hDEADBEEF);
    chk("stray_flags", 32'({busy, done, id_ok}), 32'd0);

    // 4: slave accepts but never returns data.
    drop_rdv = 1'b1;
    pulse_start();
    wait_done("t4", 1, lat);
    chk("t4_lat", 32'(lat), 32'(TMO + 1));
    chk("t4_timeout", 32'(timeout_err), 32'd1);
    chk("t4_id_ok", 32'(id_ok), 32'd0);
    chk("t4_read", 32'(avm_read), 32'd0);
    @(negedge clock);

    // 5: reset during ID_WAIT clears everything at once.
    pulse_start();
    @(negedge clock);
    chk("t5_busy_wait", 32'(busy), 32'd1);
    chk("t5_read_wait", 32'(avm_read), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_outs", 32'({busy, done, id_ok, ts_ok, timeout_err, avm_read, avm_address}), 32'd0);
    chk("t5_rst_id_value", id_value, 32'd0);
    @(negedge clock) reset = 1'b0;
    drop_rdv = 1'b0;
    mem0 = 32'd0;
    pulse_start();
    wait_done("t5b", 1, lat);
    chk("t5b_lat", 32'(lat), 32'(LAT_PASS));
    chk("t5b_id_ok", 32'(id_ok), 32'd1);
    chk("t5b_ts_ok", 32'(ts_ok), 32'(TS_EXP));
    chk("t5b_timeout", 32'(timeout_err), 32'd0);
    @(negedge clock);

    // 6: word 1 is only ever addressed in the timestamp build.
    chk("addr_one_seen", 32'(addr_one_seen), 32'(TS_EXP));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
